mem_access_ctrl: RTL and testbench



---
 rtl/mem_access_pkg.sv | 32 +++
 rtl/mem_access_ctrl_if.sv | 43 ++++
 rtl/mem_lane_mux.sv | 56 +++++
 rtl/mem_access_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared encodings, state type and defaults for the load/store controller
package mem_access_pkg;

  localparam int TIMEOUT_CYCLES_DEFAULT = 16;
  localparam int ADDR_WIDTH_DEFAULT     = 10;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_ISSUE = 3'd1,
    ST_RD_WAIT  = 3'd2,
    ST_WR_ISSUE = 3'd3,
    ST_WR_WAIT  = 3'd4,
    ST_RESP     = 3'd5
  } state_e;

  // Illegal size or an address not aligned to the access size.
  function automatic logic req_error(input logic [1:0] size, input logic [1:0] offset);
    logic err;
    case (size)
      SIZE_BYTE: err = 1'b0;
      SIZE_HALF: err = offset[0];
      SIZE_WORD: err = (offset != 2'b00);
      default:   err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - core request/response and memory handshake bundle
interface mem_access_ctrl_if #(
  parameter int ADDR_WIDTH = 10
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_signed;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;

  logic                  resp_valid;
  logic                  resp_err;
  logic [31:0]           resp_rdata;

  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_read_addr;
  logic [ADDR_WIDTH-1:0] mem_write_addr;
  logic [31:0]           mem_wr_data;
  logic [31:0]           mem_rd_data;
  logic                  mem_wr_done;
  logic                  mem_rd_done;

  // Controller view: serves the core, masters the memory.
  modport master (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  mem_rd_data, mem_wr_done, mem_rd_done,
    output req_ready, resp_valid, resp_err, resp_rdata,
    output mem_read, mem_write, mem_read_addr, mem_write_addr, mem_wr_data
  );

  // Environment view: core issuing requests plus the memory block.
  modport slave (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output mem_rd_data, mem_wr_done, mem_rd_done,
    input  req_ready, resp_valid, resp_err, resp_rdata,
    input  mem_read, mem_write, mem_read_addr, mem_write_addr, mem_wr_data
  );

endinterface

// File: rtl/mem_lane_mux.sv
// rtl/mem_lane_mux.sv - big-endian lane extraction with extension, and sub-word store merge
module mem_lane_mux
  import mem_access_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_signed,
  input  logic [31:0] st_data,
  output logic [31:0] ld_data,
  output logic [31:0] merged_word
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Lowest address lives in the most significant lane.
  always_comb begin
    byte_v = rd_word[31:24];
    case (offset)
      2'd0:    byte_v = rd_word[31:24];
      2'd1:    byte_v = rd_word[23:16];
      2'd2:    byte_v = rd_word[15:8];
      default: byte_v = rd_word[7:0];
    endcase
    half_v = offset[1] ? rd_word[15:0] : rd_word[31:16];

    ld_data = rd_word;
    case (size)
      SIZE_BYTE: ld_data = {{24{is_signed & byte_v[7]}}, byte_v};
      SIZE_HALF: ld_data = {{16{is_signed & half_v[15]}}, half_v};
      default:   ld_data = rd_word;
    endcase
  end

  // Replace only the addressed lanes of the word just read.
  always_comb begin
    merged_word = rd_word;
    case (size)
      SIZE_BYTE: begin
        case (offset)
          2'd0:    merged_word[31:24] = st_data[7:0];
          2'd1:    merged_word[23:16] = st_data[7:0];
          2'd2:    merged_word[15:8]  = st_data[7:0];
          default: merged_word[7:0]   = st_data[7:0];
        endcase
      end
      SIZE_HALF: begin
        if (offset[1]) merged_word[15:0]  = st_data[15:0];
        else           merged_word[31:16] = st_data[15:0];
      end
      default: merged_word = st_data;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - load/store controller top; MEM_ACCESS_TIMEOUT_EN enables the done timeout
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter int ADDR_WIDTH     = ADDR_WIDTH_DEFAULT
) (
  input logic               clk,
  input logic               rst_n,
  mem_access_ctrl_if.master bus
);

  localparam logic [2:0] IDLE     = ST_IDLE;
  localparam logic [2:0] RD_ISSUE = ST_RD_ISSUE;
  localparam logic [2:0] RD_WAIT  = ST_RD_WAIT;
  localparam logic [2:0] WR_ISSUE = ST_WR_ISSUE;
  localparam logic [2:0] WR_WAIT  = ST_WR_WAIT;
  localparam logic [2:0] RESP     = ST_RESP;

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            size_q, size_d;
  logic                  we_q, we_d;
  logic                  signed_q, signed_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           wr_data_q, wr_data_d;
  logic [31:0]           resp_rdata_q, resp_rdata_d;
  logic                  resp_err_q, resp_err_d;

  logic [31:0]           ld_data;
  logic [31:0]           merged_word;
  logic [ADDR_WIDTH-1:0] word_addr;

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             timeout;
  assign timeout = (wait_cnt_q == CNT_LAST);
`endif

  mem_lane_mux u_lane_mux (
    .rd_word     (bus.mem_rd_data),
    .offset      (addr_q[1:0]),
    .size        (size_q),
    .is_signed   (signed_q),
    .st_data     (wdata_q),
    .ld_data     (ld_data),
    .merged_word (merged_word)
  );

  assign word_addr          = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign bus.req_ready      = (state_q == IDLE);
  assign bus.resp_valid     = (state_q == RESP);
  assign bus.resp_err       = resp_err_q;
  assign bus.resp_rdata     = resp_rdata_q;
  assign bus.mem_read       = (state_q == RD_ISSUE);
  assign bus.mem_write      = (state_q == WR_ISSUE);
  assign bus.mem_read_addr  = word_addr;
  assign bus.mem_write_addr = word_addr;
  assign bus.mem_wr_data    = wr_data_q;

  // Sequence accept, read, optional merge/write and the one-cycle response.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    size_d       = size_q;
    we_d         = we_q;
    signed_d     = signed_q;
    wdata_d      = wdata_q;
    wr_data_d    = wr_data_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
`ifdef MEM_ACCESS_TIMEOUT_EN
    wait_cnt_d   = wait_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_d    = bus.req_addr;
          size_d    = bus.req_size;
          we_d      = bus.req_we;
          signed_d  = bus.req_signed;
          wdata_d   = bus.req_wdata;
          wr_data_d = bus.req_wdata;
          if (req_error(bus.req_size, bus.req_addr[1:0])) begin
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'h0;
            state_d      = RESP;
          end else if (bus.req_we && (bus.req_size == SIZE_WORD)) begin
            state_d = WR_ISSUE;
          end else begin
            state_d = RD_ISSUE;
          end
        end
      end
      RD_ISSUE: begin
        state_d = RD_WAIT;
`ifdef MEM_ACCESS_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      RD_WAIT: begin
        if (bus.mem_rd_done) begin
          if (we_q) begin
            wr_data_d = merged_word;
            state_d   = WR_ISSUE;
          end else begin
            resp_rdata_d = ld_data;
            resp_err_d   = 1'b0;
            state_d      = RESP;
          end
        end
`ifdef MEM_ACCESS_TIMEOUT_EN
        else if (timeout) begin
          resp_rdata_d = 32'h0;
          resp_err_d   = 1'b1;
          state_d      = RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
`endif
      end
      WR_ISSUE: begin
        state_d = WR_WAIT;
`ifdef MEM_ACCESS_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      WR_WAIT: begin
        if (bus.mem_wr_done) begin
          resp_rdata_d = 32'h0;
          resp_err_d   = 1'b0;
          state_d      = RESP;
        end
`ifdef MEM_ACCESS_TIMEOUT_EN
        else if (timeout) begin
          resp_rdata_d = 32'h0;
          resp_err_d   = 1'b1;
          state_d      = RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and captured request/response registers; reset aborts any transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      size_q       <= 2'b00;
      we_q         <= 1'b0;
      signed_q     <= 1'b0;
      wdata_q      <= 32'h0;
      wr_data_q    <= 32'h0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      we_q         <= we_d;
      signed_q     <= signed_d;
      wdata_q      <= wdata_d;
      wr_data_q    <= wr_data_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

`ifdef MEM_ACCESS_TIMEOUT_EN
  // Cycles spent waiting for the current done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_cnt_q <= '0;
    else        wait_cnt_q <= wait_cnt_d;
  end
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_ctrl_if #(.ADDR_WIDTH(10)) bus ();

  mem_access_ctrl #(.TIMEOUT_CYCLES(16), .ADDR_WIDTH(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Memory model: done pulse one cycle after each request, plus event counters.
  logic [31:0] mem [0:255];
  logic        stall_rd = 1'b0;
  int          rd_total = 0;
  int          wr_total = 0;
  int          both_total = 0;
  int          resp_total = 0;

  initial begin
    bus.mem_rd_done = 1'b0;
    bus.mem_wr_done = 1'b0;
    bus.mem_rd_data = 32'h0;
  end

  always @(posedge clk) begin
    bus.mem_rd_done <= 1'b0;
    bus.mem_wr_done <= 1'b0;
    if (bus.mem_read) begin
      rd_total <= rd_total + 1;
      if (!stall_rd) begin
        bus.mem_rd_done <= 1'b1;
        bus.mem_rd_data <= mem[bus.mem_read_addr[9:2]];
      end
    end
    if (bus.mem_write) begin
      wr_total <= wr_total + 1;
      mem[bus.mem_write_addr[9:2]] <= bus.mem_wr_data;
      bus.mem_wr_done <= 1'b1;
    end
    if (bus.mem_read && bus.mem_write) both_total <= both_total + 1;
    if (bus.resp_valid) resp_total <= resp_total + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  int          lat;
  logic [31:0] rdata;
  logic        err;
  int          rd0, wr0, resp0;

  // One request: returns cycles from acceptance to resp_valid (-1 if none).
  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [9:0] addr, input logic [31:0] wdata,
                        output int l, output logic [31:0] rd, output logic e);
    int k;
    @(negedge clk);
    rd0 = rd_total;
    wr0 = wr_total;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    k = 1;
    while (!bus.resp_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    l  = bus.resp_valid ? k : -1;
    rd = bus.resp_rdata;
    e  = bus.resp_err;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = 10'h0;
    bus.req_wdata  = 32'h0;

    // Reset state
    #12;
    chk("rst_ready",  32'(bus.req_ready),  32'd1);
    chk("rst_read",   32'(bus.mem_read),   32'd0);
    chk("rst_write",  32'(bus.mem_write),  32'd0);
    chk("rst_rvalid", 32'(bus.resp_valid), 32'd0);
    chk("rst_err",    32'(bus.resp_err),   32'd0);
    chk("rst_rdata",  bus.resp_rdata,      32'h0);
    chk("rst_wdata",  bus.mem_wr_data,     32'h0);
    chk("rst_raddr",  32'(bus.mem_read_addr), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Word store then word load
    do_req(1'b1, 2'b10, 1'b0, 10'h010, 32'hDEADBEEF, lat, rdata, err);
    chk("wst_lat",   32'(lat), 32'd3);
    chk("wst_err",   32'(err), 32'd0);
    chk("wst_rdata", rdata,    32'h0);
    chk("wst_reads", 32'(rd_total - rd0), 32'd0);
    chk("wst_writes",32'(wr_total - wr0), 32'd1);
    @(negedge clk);
    chk("ready_after_resp", 32'(bus.req_ready), 32'd1);

    do_req(1'b0, 2'b10, 1'b0, 10'h010, 32'h0, lat, rdata, err);
    chk("wld_lat",   32'(lat), 32'd3);
    chk("wld_err",   32'(err), 32'd0);
    chk("wld_rdata", rdata,    32'hDEADBEEF);
    chk("wld_reads", 32'(rd_total - rd0), 32'd1);

    // Sub-word loads and response hold
    do_req(1'b0, 2'b00, 1'b1, 10'h011, 32'h0, lat, rdata, err);
    chk("bld_s_rdata", rdata, 32'hFFFFFFAD);
    @(negedge clk);
    chk("hold_rdata",  bus.resp_rdata, 32'hFFFFFFAD);
    chk("hold_valid",  32'(bus.resp_valid), 32'd0);
    do_req(1'b0, 2'b00, 1'b0, 10'h011, 32'h0, lat, rdata, err);
    chk("bld_u_rdata", rdata, 32'h000000AD);
    do_req(1'b0, 2'b01, 1'b1, 10'h010, 32'h0, lat, rdata, err);
    chk("hld_s_rdata", rdata, 32'hFFFFDEAD);
    do_req(1'b0, 2'b00, 1'b0, 10'h013, 32'h0, lat, rdata, err);
    chk("bld_u3_rdata", rdata, 32'h000000EF);

    // Halfword store (read-modify-write)
    do_req(1'b1, 2'b01, 1'b0, 10'h012, 32'hFFFF1234, lat, rdata, err);
    chk("hst_lat",    32'(lat), 32'd5);
    chk("hst_err",    32'(err), 32'd0);
    chk("hst_reads",  32'(rd_total - rd0), 32'd1);
    chk("hst_writes", 32'(wr_total - wr0), 32'd1);
    do_req(1'b0, 2'b10, 1'b0, 10'h010, 32'h0, lat, rdata, err);
    chk("hst_verify", rdata, 32'hDEAD1234);

    // Byte stores at offsets 3 and 0
    do_req(1'b1, 2'b00, 1'b0, 10'h013, 32'h0000005A, lat, rdata, err);
    chk("bst3_lat", 32'(lat), 32'd5);
    do_req(1'b1, 2'b00, 1'b0, 10'h010, 32'hAAAAAA77, lat, rdata, err);
    do_req(1'b0, 2'b10, 1'b0, 10'h010, 32'h0, lat, rdata, err);
    chk("bst_verify", rdata, 32'h77AD125A);

    // Alignment and size errors: no memory traffic
    do_req(1'b0, 2'b10, 1'b0, 10'h013, 32'h0, lat, rdata, err);
    chk("mis_lat",    32'(lat), 32'd1);
    chk("mis_err",    32'(err), 32'd1);
    chk("mis_rdata",  rdata,    32'h0);
    chk("mis_mem",    32'((rd_total - rd0) + (wr_total - wr0)), 32'd0);
    do_req(1'b1, 2'b11, 1'b0, 10'h000, 32'h12345678, lat, rdata, err);
    chk("ill_lat",    32'(lat), 32'd1);
    chk("ill_err",    32'(err), 32'd1);
    chk("ill_mem",    32'((rd_total - rd0) + (wr_total - wr0)), 32'd0);
    do_req(1'b1, 2'b01, 1'b0, 10'h021, 32'h0, lat, rdata, err);
    chk("hmis_err",   32'(err), 32'd1);

`ifdef MEM_ACCESS_TIMEOUT_EN
    // Read never completes: error after the timeout window
    stall_rd = 1'b1;
    do_req(1'b0, 2'b10, 1'b0, 10'h010, 32'h0, lat, rdata, err);
    chk("to_lat",   32'(lat), 32'd18);
    chk("to_err",   32'(err), 32'd1);
    chk("to_rdata", rdata,    32'h0);
    @(negedge clk);
    chk("to_ready", 32'(bus.req_ready), 32'd1);
    // Sub-word store stalled in its read phase never writes
    do_req(1'b1, 2'b00, 1'b0, 10'h010, 32'h0, lat, rdata, err);
    chk("to_st_err",    32'(err), 32'd1);
    chk("to_st_writes", 32'(wr_total - wr0), 32'd0);
    stall_rd = 1'b0;
`endif

    // Reset during RD_WAIT aborts with no response
    stall_rd = 1'b1;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'b10;
    bus.req_signed = 1'b0;
    bus.req_addr   = 10'h010;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("mid_addr", 32'(bus.mem_read_addr), 32'h010);
    resp0 = resp_total;
    rst_n = 1'b0;
    #1;
    chk("mid_ready", 32'(bus.req_ready),  32'd1);
    chk("mid_valid", 32'(bus.resp_valid), 32'd0);
    chk("mid_read",  32'(bus.mem_read),   32'd0);
    chk("mid_raddr", 32'(bus.mem_read_addr), 32'h0);
    chk("mid_rdata", bus.resp_rdata, 32'h0);
    chk("mid_err",   32'(bus.resp_err), 32'd0);
    repeat (3) @(negedge clk);
    stall_rd = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_no_resp", 32'(resp_total - resp0), 32'd0);
    do_req(1'b0, 2'b10, 1'b0, 10'h010, 32'h0, lat, rdata, err);
    chk("post_rst_lat",   32'(lat), 32'd3);
    chk("post_rst_rdata", rdata,    32'h77AD125A);

    chk("never_both", 32'(both_total), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
